// File: rtl/axi4_lite_cmd_queue.sv
// axi4_lite_cmd_queue
// Host-side command FIFO feeding a single-outstanding AXI4-lite master.
// Commands {write, addr, wdata} are queued, popped one at a time into an
// issue register, started with a one-cycle read_s/write_s strobe, and
// reported once with rsp_valid/rsp_resp when the master signals txn_done.
//
// Optional feature macro: AXI_CMD_TIMEOUT_EN
//   When defined, a WAIT-state counter aborts a transaction after TIMEOUT
//   cycles without txn_done and reports rsp_resp = 2'b11.
//   When undefined, WAIT holds until txn_done and no counter exists.

// Protocol checker kept apart from the datapath; bound inside the top.
module axi4_lite_cmd_queue_chk #(
  parameter int DEPTH = 4
) (
  input logic                   ACLK,
  input logic                   ARESET,
  input logic                   read_s,
  input logic                   write_s,
  input logic                   rsp_valid,
  input logic                   cmd_ready,
  input logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  a_issue_onehot : assert property (@(posedge ACLK) disable iff (ARESET)
    !(read_s && write_s));

  a_issue_pulse : assert property (@(posedge ACLK) disable iff (ARESET)
    (read_s || write_s) |=> !(read_s || write_s));

  a_rsp_pulse : assert property (@(posedge ACLK) disable iff (ARESET)
    rsp_valid |=> !rsp_valid);

  a_level_max : assert property (@(posedge ACLK) disable iff (ARESET)
    level <= LVL_FULL);

  a_ready_level : assert property (@(posedge ACLK) disable iff (ARESET)
    cmd_ready == (level != LVL_FULL));

endmodule

module axi4_lite_cmd_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS    = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDRESS-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]  cmd_wdata,
  output logic                   read_s,
  output logic                   write_s,
  output logic [ADDRESS-1:0]     address,
  output logic [DATA_WIDTH-1:0]  W_data,
  input  logic                   txn_done,
  input  logic [1:0]             txn_resp,
  output logic                   rsp_valid,
  output logic [1:0]             rsp_resp,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 1 + ADDRESS + DATA_WIDTH;

  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_EMPTY = {LW{1'b0}};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  // Reject configurations the pointer arithmetic cannot handle.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("axi4_lite_cmd_queue: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  // FIFO storage and bookkeeping
  logic [EW-1:0]         mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;

  // Control FSM and the registered issue/report outputs
  logic [1:0]            state_q, state_d;
  logic                  rd_s_q, rd_s_d;
  logic                  wr_s_q, wr_s_d;
  logic [ADDRESS-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;

  logic                  push_s;
  logic                  pop_s;
  logic [EW-1:0]         head_s;
  logic                  head_write_s;
  logic [ADDRESS-1:0]    head_addr_s;
  logic [DATA_WIDTH-1:0] head_wdata_s;

  assign cmd_ready = (level_q != LVL_FULL);
  assign push_s    = cmd_valid && cmd_ready;
  // The only pop point is the IDLE->ISSUE edge, so one command is in flight at most.
  assign pop_s     = (state_q == ST_IDLE) && (level_q != LVL_EMPTY);

  assign head_s       = mem_q[rd_ptr_q];
  assign head_write_s = head_s[EW-1];
  assign head_addr_s  = head_s[EW-2 -: ADDRESS];
  assign head_wdata_s = head_s[DATA_WIDTH-1:0];

`ifdef AXI_CMD_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT - 1);
  localparam logic [1:0]    RESP_TIMEOUT = 2'b11;

  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_expired_s;

  // Count consecutive WAIT cycles; restart from zero on every entry to WAIT.
  always_comb begin
    if (state_q == ST_WAIT) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = {TW{1'b0}};
    end
  end

  // Expired once the final permitted WAIT cycle is reached without txn_done.
  assign tmo_expired_s = (tmo_q == TMO_LAST);

  // Timeout counter register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      tmo_q <= {TW{1'b0}};
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  // Next pointers and occupancy; a simultaneous push and pop leaves level unchanged.
  always_comb begin
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FSM next state plus the issue register and response capture.
  always_comb begin
    state_d     = state_q;
    rd_s_d      = 1'b0;
    wr_s_d      = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d = ST_ISSUE;
          wr_s_d  = head_write_s;
          rd_s_d  = ~head_write_s;
          addr_d  = head_addr_s;
          if (head_write_s) begin
            wdata_d = head_wdata_s;
          end else begin
            wdata_d = {DATA_WIDTH{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (txn_done) begin
          state_d     = ST_REPORT;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = txn_resp;
        end
`ifdef AXI_CMD_TIMEOUT_EN
        else if (tmo_expired_s) begin
          state_d     = ST_REPORT;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = RESP_TIMEOUT;
        end
`endif
        else begin
          state_d = ST_WAIT;
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO payload write; contents need no reset because level gates every read.
  always_ff @(posedge ACLK) begin
    if (push_s && !ARESET) begin
      mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  // Control, pointer and output registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      level_q     <= {LW{1'b0}};
      state_q     <= ST_IDLE;
      rd_s_q      <= 1'b0;
      wr_s_q      <= 1'b0;
      addr_q      <= {ADDRESS{1'b0}};
      wdata_q     <= {DATA_WIDTH{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_resp_q  <= 2'b00;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      rd_s_q      <= rd_s_d;
      wr_s_q      <= wr_s_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign read_s    = rd_s_q;
  assign write_s   = wr_s_q;
  assign address   = addr_q;
  assign W_data    = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_resp  = rsp_resp_q;
  assign level     = level_q;

  axi4_lite_cmd_queue_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .read_s    (rd_s_q),
    .write_s   (wr_s_q),
    .rsp_valid (rsp_valid_q),
    .cmd_ready (cmd_ready),
    .level     (level_q)
  );

endmodule

// File: tb/tb_axi4_lite_cmd_queue.sv
// Self-checking bench for axi4_lite_cmd_queue (scoreboard style).
// Expected issues and responses are queued when stimulus is driven and
// compared by a monitor when the DUT produces strobes.
module tb_axi4_lite_cmd_queue;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          ACLK      = 1'b0;
  logic          ARESET    = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          read_s;
  logic          write_s;
  logic [AW-1:0] address;
  logic [DW-1:0] W_data;
  logic          txn_done  = 1'b0;
  logic [1:0]    txn_resp  = 2'b00;
  logic          rsp_valid;
  logic [1:0]    rsp_resp;
  logic [LW-1:0] level;

  axi4_lite_cmd_queue #(
    .DATA_WIDTH (DW),
    .ADDRESS    (AW),
    .DEPTH      (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .read_s    (read_s),
    .write_s   (write_s),
    .address   (address),
    .W_data    (W_data),
    .txn_done  (txn_done),
    .txn_resp  (txn_resp),
    .rsp_valid (rsp_valid),
    .rsp_resp  (rsp_resp),
    .level     (level)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] rsp_q[$];

  int checks     = 0;
  int failures   = 0;
  int issued_cnt = 0;
  int done_cnt   = 0;
  int rsp_cnt    = 0;
  int cyc        = 0;
  int last_issue_cyc = -100;
  int last_gap   = 0;
  int rsp_base   = 0;
  logic prev_issue = 1'b0;
  logic prev_rsp   = 1'b0;
  logic [AW-1:0] last_addr  = '0;
  logic [DW-1:0] last_wdata = '0;
  exp_t mon_e;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: sample just after each rising edge, score issues and responses.
  always @(posedge ACLK) begin
    #1;
    cyc++;
    if (read_s || write_s) begin
      check_eq("issue_onehot", 64'(read_s & write_s), 64'd0);
      check_eq("issue_pulse", 64'(prev_issue), 64'd0);
      if (exp_q.size() == 0) begin
        check_eq("issue_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("issue_kind", 64'(write_s), 64'(mon_e.w));
        check_eq("issue_addr", 64'(address), 64'(mon_e.a));
        check_eq("issue_wdata", 64'(W_data), 64'(mon_e.d));
        last_addr  = mon_e.a;
        last_wdata = mon_e.d;
      end
      last_gap       = cyc - last_issue_cyc;
      last_issue_cyc = cyc;
      issued_cnt++;
    end
    if (rsp_valid) begin
      check_eq("rsp_pulse", 64'(prev_rsp), 64'd0);
      if (rsp_q.size() == 0) begin
        check_eq("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        check_eq("rsp_resp", 64'(rsp_resp), 64'(rsp_q.pop_front()));
      end
      rsp_cnt++;
    end
    prev_issue = read_s | write_s;
    prev_rsp   = rsp_valid;
  end

  // Wait (bounded) until the DUT has issued a command not yet completed.
  task automatic wait_issue();
    int n = 0;
    while (issued_cnt <= done_cnt && n < 64) begin
      @(negedge ACLK);
      n++;
    end
    if (issued_cnt <= done_cnt) check_eq("wait_issue_timeout", 64'd1, 64'd0);
  endtask

  // Offer a command (holding it until accepted) and record its expected issue.
  task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 64) begin
      @(negedge ACLK);
      n++;
    end
    if (cmd_ready) begin
      e = '{w, a, (w ? d : 32'd0)};
      exp_q.push_back(e);
    end else begin
      check_eq("push_stall", 64'd1, 64'd0);
    end
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  // Complete the in-flight command with response r during WAIT.
  task automatic complete_one(input logic [1:0] r);
    wait_issue();
    @(negedge ACLK);
    check_eq("addr_stable", 64'(address), 64'(last_addr));
    check_eq("wdata_stable", 64'(W_data), 64'(last_wdata));
    rsp_q.push_back(r);
    txn_done = 1'b1;
    txn_resp = r;
    @(negedge ACLK);
    txn_done = 1'b0;
    txn_resp = 2'b00;
    check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
    done_cnt++;
  endtask

  // Push into an empty idle queue and check the 2-cycle issue latency.
  task automatic push_latency(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    check_eq("lat_ready", 64'(cmd_ready), 64'd1);
    check_eq("lat_level0", 64'(level), 64'd0);
    push_cmd(w, a, d);
    check_eq("lat_level1", 64'(level), 64'd1);
    check_eq("lat_early", 64'(read_s | write_s), 64'd0);
    @(negedge ACLK);
    check_eq("lat_write_s", 64'(write_s), 64'(w));
    check_eq("lat_read_s", 64'(read_s), 64'(!w));
    check_eq("lat_level_pop", 64'(level), 64'd0);
    @(negedge ACLK);
    check_eq("lat_after", 64'(read_s | write_s), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and reset-state checks
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    check_eq("rst_level", 64'(level), 64'd0);
    check_eq("rst_ready", 64'(cmd_ready), 64'd1);
    check_eq("rst_read_s", 64'(read_s), 64'd0);
    check_eq("rst_write_s", 64'(write_s), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_address", 64'(address), 64'd0);
    check_eq("rst_wdata", 64'(W_data), 64'd0);
    check_eq("rst_rsp_resp", 64'(rsp_resp), 64'd0);

    // txn_done while idle must be ignored
    txn_done = 1'b1;
    txn_resp = 2'b01;
    @(negedge ACLK);
    txn_done = 1'b0;
    txn_resp = 2'b00;
    check_eq("idle_done_ignored", 64'(rsp_valid), 64'd0);
    @(negedge ACLK);
    check_eq("idle_done_ignored2", 64'(rsp_valid), 64'd0);

    // Single write with OKAY response
    push_latency(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    complete_one(2'b00);
    @(negedge ACLK);
    check_eq("rsp_one_cycle", 64'(rsp_valid), 64'd0);

    // Single read with SLVERR response; W_data must be zero
    push_latency(1'b0, 32'h0000_0020, 32'h1234_5678);
    complete_one(2'b10);
    @(negedge ACLK);

    // Fill the queue back-to-back with no completions
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      cmd_valid = 1'b1;
      cmd_write = i[0];
      cmd_addr  = 32'h0000_0100 + 32'(i * 4);
      cmd_wdata = 32'hA000_0000 + 32'(i);
      check_eq("fill_ready", 64'(cmd_ready), 64'd1);
      e = '{cmd_write, cmd_addr, (cmd_write ? cmd_wdata : 32'd0)};
      exp_q.push_back(e);
      @(negedge ACLK);
    end
    check_eq("full_level", 64'(level), 64'(DEPTH));
    check_eq("full_ready", 64'(cmd_ready), 64'd0);
    begin
      exp_t e6;
      int n;
      cmd_write = 1'b1;
      cmd_addr  = 32'h0000_0200;
      cmd_wdata = 32'hB0B0_0006;
      e6 = '{1'b1, 32'h0000_0200, 32'hB0B0_0006};
      exp_q.push_back(e6);
      repeat (3) begin
        @(negedge ACLK);
        check_eq("held_level", 64'(level), 64'(DEPTH));
        check_eq("held_ready", 64'(cmd_ready), 64'd0);
      end
      complete_one(2'b01);
      n = 0;
      while (!cmd_ready && n < 32) begin
        @(negedge ACLK);
        n++;
      end
      check_eq("slot_freed", 64'(cmd_ready), 64'd1);
      @(negedge ACLK);
      cmd_valid = 1'b0;
      check_eq("refill_level", 64'(level), 64'(DEPTH));
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        wait_issue();
        if (i > 1) check_eq("issue_spacing", 64'(last_gap), 64'd4);
      end
      complete_one(2'(i));
    end
    @(negedge ACLK);
    check_eq("drain_level", 64'(level), 64'd0);
    check_eq("drain_exp_empty", 64'(exp_q.size()), 64'd0);

    // Reset while a command is in WAIT and another is queued
    push_cmd(1'b1, 32'h0000_0030, 32'h55AA_55AA);
    wait_issue();
    @(negedge ACLK);
    push_cmd(1'b0, 32'h0000_0034, 32'h0000_0000);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    exp_q.delete();
    rsp_q.delete();
    done_cnt = issued_cnt;
    txn_done = 1'b1;
    txn_resp = 2'b00;
    @(negedge ACLK);
    txn_done = 1'b0;
    check_eq("mid_rst_level", 64'(level), 64'd0);
    check_eq("mid_rst_ready", 64'(cmd_ready), 64'd1);
    check_eq("mid_rst_address", 64'(address), 64'd0);
    repeat (3) begin
      @(negedge ACLK);
      check_eq("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    push_latency(1'b1, 32'h0000_0040, 32'h0BAD_F00D);
    complete_one(2'b00);
    @(negedge ACLK);

`ifdef AXI_CMD_TIMEOUT_EN
    // Timeout with a second command queued behind it
    push_cmd(1'b0, 32'h0000_0050, 32'h0000_0000);
    push_cmd(1'b1, 32'h0000_0054, 32'hCAFE_F00D);
    wait_issue();
    rsp_q.push_back(2'b11);
    for (int k = 0; k < TMO; k++) begin
      @(negedge ACLK);
      check_eq("tmo_early", 64'(rsp_valid), 64'd0);
    end
    @(negedge ACLK);
    check_eq("tmo_report", 64'(rsp_valid), 64'd1);
    done_cnt++;
    complete_one(2'b01);
    @(negedge ACLK);
    check_eq("tmo_level", 64'(level), 64'd0);
`endif

    // 2*DEPTH+1 commands with immediate completions across pointer wrap
    rsp_base = rsp_cnt;
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      push_cmd(i[0], 32'h0000_0300 + 32'(i * 4), 32'h0000_1000 + 32'(i));
      complete_one(2'(i));
    end
    @(negedge ACLK);
    @(negedge ACLK);
    check_eq("wrap_level", 64'(level), 64'd0);
    check_eq("wrap_rsp_count", 64'(rsp_cnt - rsp_base), 64'(2 * DEPTH + 1));
    check_eq("wrap_exp_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_lite_cmd_queue.md
AXI4_LITE_CMD_QUEUE -- requirements
Module: axi4_lite_cmd_queue

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, data width; ADDRESS, 32, address width; DEPTH, 4, command FIFO entries (power of 2, >=2); TIMEOUT, 255, completion wait limit in cycles.
REQ-002 SHALL have ports:
- ACLK  in  1  single clock; all logic rising-edge.
- ARESET  in  1  synchronous active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO can accept.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDRESS  command address.
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads).
- read_s  out  1  one-cycle read start to the AXI4-lite master.
- write_s  out  1  one-cycle write start to the AXI4-lite master.
- address  out  ADDRESS  address to the master.
- W_data  out  DATA_WIDTH  write data to the master.
- txn_done  in  1  master completion pulse (B or R handshake).
- txn_resp  in  2  xRESP of the completed transaction.
- rsp_valid  out  1  one-cycle completion report.
- rsp_resp  out  2  response code; 2'b11 on timeout.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-003 FIFO SHALL store {write, addr, wdata}; push when cmd_valid && cmd_ready; cmd_ready = (level != DEPTH).
REQ-004 FSM SHALL have states IDLE, ISSUE, WAIT, REPORT.
REQ-005 IDLE -> ISSUE when level != 0; head entry SHALL be popped into an issue register on that edge.
REQ-006 In ISSUE, exactly one of read_s/write_s SHALL be high for exactly one cycle, per the stored write bit; next state WAIT.
REQ-007 address and W_data SHALL come from the issue register and stay stable from ISSUE until leaving WAIT; W_data SHALL be 0 for reads.
REQ-008 WAIT -> REPORT on txn_done; txn_resp SHALL be captured. txn_done outside WAIT SHALL be ignored.
REQ-009 REPORT SHALL assert rsp_valid for one cycle with the captured response, then go to IDLE; issue-to-issue minimum spacing is 4 cycles.
REQ-010 Simultaneous push and pop SHALL leave level unchanged; push when full SHALL be refused (cmd_ready low); pop never occurs when empty.
REQ-011 Pointers SHALL wrap modulo DEPTH; level SHALL be exact across wrap.
REQ-012 Commands SHALL issue strictly in push order, one outstanding at a time.
REQ-013 Push-to-read_s/write_s latency SHALL be 2 cycles from an empty, idle queue (push edge, pop edge, ISSUE cycle).

Reset
REQ-014 While ARESET is high on an ACLK edge: FIFO emptied, pointers 0, level 0, state IDLE, read_s/write_s/rsp_valid 0, address/W_data 0, rsp_resp 0; cmd_ready SHALL be 1 in the cycle after.
REQ-015 Reset mid-transaction SHALL discard the in-flight command without an rsp_valid report; a late txn_done after reset SHALL be ignored.

Configuration
REQ-016 With AXI_CMD_TIMEOUT_EN defined, a counter SHALL run in WAIT; after TIMEOUT cycles without txn_done, go to REPORT with rsp_resp = 2'b11 (timeout).
REQ-017 Without AXI_CMD_TIMEOUT_EN, WAIT SHALL persist indefinitely until txn_done; no counter logic present.

Verification
REQ-018 Reset, push write addr 0x10 data 0xDEADBEEF -> write_s pulses 2 cycles after push, address 0x10, W_data 0xDEADBEEF; txn_done with resp 00 -> rsp_valid one cycle, rsp_resp 00.
REQ-019 Push 5 commands back-to-back with DEPTH 4, no txn_done -> cmd_ready low once level reaches 4, 5th held until a slot frees; commands issue in push order.
REQ-020 Read at 0x20, txn_done with resp 2'b10 -> read_s pulse only, W_data 0, rsp_resp 2'b10.
REQ-021 Assert ARESET during WAIT, then txn_done -> no rsp_valid, level 0, state IDLE.
REQ-022 AXI_CMD_TIMEOUT_EN defined, TIMEOUT 8, no txn_done -> rsp_valid with rsp_resp 2'b11 after 8 WAIT cycles; next queued command then issues.
REQ-023 Push 2*DEPTH+1 commands with immediate completions -> pointer wrap, level returns 0, all reports in order.
